dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the single-cycle/multi-cycle RISC-V core: serves the load/store requests issued by the datapath and returns the `read_data` value that feeds the result mux. Accepts one request at a time over a valid/ready handshake. Applies RV32I byte/half/word semantics: byte-lane stores, sign/zero-extended loads and misalignment checks. Returns the response after a parameterised latency, which lets the core be exercised against a non-ideal memory.

## Interface
- `D_WIDTH`, 32, data width (fixed at 32 for RV32I lane logic)
- `A_WIDTH`, 12, byte-address width; memory holds 2^A_WIDTH bytes as 2^(A_WIDTH-2) words
- `LATENCY`, 2, cycles from request accept to `rsp_valid`; legal range 1..15
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3 of the load/store
- `req_addr`  in  A_WIDTH  byte address
- `req_wdata`  in  D_WIDTH  store data (rs2), low bits used for SB/SH
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  datapath takes the response
- `rsp_rdata`  out  D_WIDTH  extended load data; 0 for stores and errors
- `rsp_err`  out  1  misaligned access or illegal funct3

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1. If `req_valid`=1, the request is accepted at this edge.
  - Go to WAIT with the counter loaded to LATENCY-1 when LATENCY>1.
  - Go straight to RESP when LATENCY=1.
- WAIT: the counter decrements each cycle. When it reaches 0, go to RESP.
- RESP: `rsp_valid`=1 and the outputs are held stable. Go to IDLE on the edge where `rsp_ready`=1.
- `req_ready`=0 in WAIT and RESP. No request is accepted while in RESP.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 sets `rsp_err`.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, sets `rsp_err`.
- On any error: no array write, and `rsp_rdata`=0.
- Stores write only the addressed byte lanes. SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}. The memory is little-endian.
- Array write and array read both occur on the accept edge; the read returns the old contents (irrelevant, because a store's response data is 0). The load result is registered at accept and presented at RESP.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Address bits above A_WIDTH do not exist; all addresses in range are mapped.

## Timing
- Reset values: `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter=0. The array is not reset; its contents are undefined.
- Accept at edge N → `rsp_valid` high from edge N+LATENCY.
- Minimum spacing between accepts is LATENCY+1 cycles; `rsp_ready` held high achieves this.
- `rsp_rdata` and `rsp_err` are stable for the whole time `rsp_valid`=1.
- A store accepted at edge N is visible to a load accepted at any later edge.
- Reset asserted in WAIT or RESP: return to IDLE immediately and drop the pending response. A store already accepted stays committed.
- `req_*` inputs are ignored outside IDLE. `rsp_ready` is ignored outside RESP.

## Structure
- `dmem_pkg` holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the `dmem_state_t` enum {IDLE, WAIT, RESP}
  - function `dmem_misaligned(funct3, addr[1:0])`
- Sub-module `dmem_load_align`: combinational. Takes the 32-bit word, addr[1:0] and funct3, and produces the extended load value. It is shared with a future instruction-fetch/cache path.
- Top level contains the FSM, the latency counter, the byte-lane write logic and the word array.

## Test plan
- Reset then SW 0xDEADBEEF @0x010, LW @0x010, LATENCY=2 → LW `rsp_valid` two cycles after accept, rdata 0xDEADBEEF, err 0.
- SB 0x80 @0x021 over a word pre-written 0x00000000. Then:
  - LB @0x021 → 0xFFFFFF80
  - LBU @0x021 → 0x00000080
  - LW @0x020 → 0x00008000
- SH @0x031 → err 1, no write. Then LW @0x030 returns the prior value unchanged. LW @0x002 → err 1, rdata 0. funct3=011 → err 1.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, rdata and err stay stable, and `req_ready` stays 0. Raise `rsp_ready` → IDLE next cycle, and a new request is accepted.
- Assert `rst` mid-WAIT after accepting SW 0x12345678 @0x040 → `rsp_valid` never rises and state returns to IDLE. A later LW @0x040 returns 0x12345678.
- Rerun with LATENCY=1 and LATENCY=15 using back-to-back requests with `rsp_ready`=1 → accepts are exactly LATENCY+1 cycles apart.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM state type and access-check helpers for the data-memory responder
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic dmem_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3)
            F3_H, F3_HU: return addr[0];
            F3_W:        return addr != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Stores have no unsigned variants, so the legal set depends on direction.
    function automatic logic dmem_illegal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return !(funct3 inside {F3_B, F3_H, F3_W});
        end
        return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects and sign/zero-extends the addressed byte or halfword of a 32-bit word
// Ports:
//   word   in  32  little-endian memory word
//   addr   in  2   byte offset within the word
//   funct3 in  3   RV32I load funct3
//   data   out 32  extended load value (0 for non-load funct3)
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_W:    data = word;
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I load/store responder with byte-lane writes and configurable response latency
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake, accepted only in IDLE
//   req_we, req_funct3          store flag and RV32I funct3
//   req_addr, req_wdata         byte address and store data
//   rsp_valid/rsp_ready         response handshake, held in RESP until taken
//   rsp_rdata, rsp_err          extended load data (0 on store/error), error flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 12,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [D_WIDTH-1:0] rsp_rdata,
    output logic               rsp_err
);

    localparam int         WORDS    = 2 ** (A_WIDTH - 2);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [D_WIDTH-1:0] mem [WORDS];

    dmem_state_t        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               accept;
    logic [A_WIDTH-3:0] word_idx;
    logic [1:0]         lane;
    logic               req_err;
    logic               mem_we;
    logic [3:0]         be;
    logic [31:0]        wlanes;
    logic [31:0]        rd_word;
    logic [31:0]        ld_data;

    assign word_idx = req_addr[A_WIDTH-1:2];
    assign lane     = req_addr[1:0];
    assign req_err  = dmem_illegal(req_we, req_funct3) || dmem_misaligned(req_funct3, lane);
    assign mem_we   = accept && req_we && !req_err;
    assign rd_word  = mem[word_idx];

    // Replicate store data across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be     = 4'b0000;
        wlanes = req_wdata;
        case (req_funct3)
            F3_B: begin
                be     = 4'b0001 << lane;
                wlanes = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{req_wdata[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // The array is deliberately not reset; a store survives a reset that follows its accept.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    dmem_load_align u_load_align (
        .word   (rd_word),
        .addr   (lane),
        .funct3 (req_funct3),
        .data   (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The transition to RESP happens on the edge where the counter reaches 0,
    // so RESP is entered LATENCY-1 edges after accept and is seen high at edge N+LATENCY.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response payload is captured once at accept and held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_err   <= req_err;
            rsp_rdata <= (req_we || req_err) ? '0 : ld_data;
        end
    end

endmodule
